mdu_iter: RTL and testbench



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_div_step.sv | 28 ++
 rtl/mdu_iter.sv | 214 +++++++++++++++++++++
 tb/tb_mdu_iter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM states
// and a two's-complement helper.
package mdu_pkg;

    // Widest operand supported by neg2c; callers zero-extend into it and truncate back.
    localparam int unsigned MDU_NEG_W = 128;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } mdu_state_e;

    // Two's-complement negate; the low bits stay correct after truncation.
    function automatic logic [MDU_NEG_W-1:0] neg2c(input logic [MDU_NEG_W-1:0] x);
        return ~x + MDU_NEG_W'(1);
    endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the
// divisor, keep the difference when it does not borrow.
module mdu_div_step
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_div,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_ge;

    // Trial subtraction and restore select.
    always_comb begin
        w_shift = {i_rem[WIDTH-1:0], i_bit};
        w_diff  = w_shift - {1'b0, i_div};
        w_ge    = i_rem[WIDTH] | (w_shift >= {1'b0, i_div});
        o_qbit  = w_ge;
        o_rem   = w_ge ? w_diff : w_shift;
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative HI/LO multiply/divide unit, one bit per cycle, with pipeline flush.
// Optional feature: define MDU_FAST_MUL_EN for a single-cycle multiply path
// (IDLE -> DONE); divides stay iterative either way.
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_dbz
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    mdu_state_e       r_state;
    mdu_state_e       w_next;
    logic [CW-1:0]    r_cnt;
    logic [W2-1:0]    r_acc;       // MUL: {partial product, multiplier}; DIV: low half = dividend/quotient
    logic [WIDTH-1:0] r_opd;       // multiplicand or divisor magnitude
    logic [WIDTH:0]   r_rem;
    logic             r_is_div;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_dbz_pend;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    mdu_op_e          w_op;
    logic             w_accept;
    logic             w_is_div;
    logic             w_is_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    // Request decode and operand magnitudes.
    always_comb begin
        w_op        = mdu_op_e'(i_op);
        w_accept    = i_start && !i_flush;
        w_is_div    = (w_op == MDU_DIV) || (w_op == MDU_DIVU);
        w_is_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
        w_a_neg     = w_is_signed && i_a[WIDTH-1];
        w_b_neg     = w_is_signed && i_b[WIDTH-1];
        w_abs_a     = w_a_neg ? WIDTH'(neg2c(MDU_NEG_W'(i_a))) : i_a;
        w_abs_b     = w_b_neg ? WIDTH'(neg2c(MDU_NEG_W'(i_b))) : i_b;
    end

    logic [WIDTH:0]  w_mul_sum;
    logic [W2-1:0]   w_mul_next;

    // Shift-add multiply step on the unsigned accumulator.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[W2-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    end

    logic [WIDTH:0] w_rem_next;
    logic           w_qbit;

    mdu_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem  (r_rem),
        .i_div  (r_opd),
        .i_bit  (r_acc[WIDTH-1]),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    logic [W2-1:0]    w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_fix_hi;
    logic [WIDTH-1:0] w_fix_lo;

    // Sign fix-up and divide-by-zero substitution for the FIX write.
    always_comb begin
        w_prod   = r_neg_lo ? W2'(neg2c(MDU_NEG_W'(r_acc))) : r_acc;
        w_quo    = r_neg_lo ? WIDTH'(neg2c(MDU_NEG_W'(r_acc[WIDTH-1:0]))) : r_acc[WIDTH-1:0];
        w_rem    = r_neg_hi ? WIDTH'(neg2c(MDU_NEG_W'(r_rem[WIDTH-1:0]))) : r_rem[WIDTH-1:0];
        w_fix_hi = r_is_div ? w_rem : w_prod[W2-1:WIDTH];
        w_fix_lo = r_is_div ? (r_dbz_pend ? '1 : w_quo) : w_prod[WIDTH-1:0];
    end

`ifdef MDU_FAST_MUL_EN
    logic [W2-1:0] w_fast_prod;

    // Single-cycle multiply on sign- or zero-extended operands.
    always_comb begin
        if (w_is_signed) begin
            w_fast_prod = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
        end else begin
            w_fast_prod = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
        end
    end
`endif

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
`ifdef MDU_FAST_MUL_EN
                    w_next = w_is_div ? ST_DIV : ST_DONE;
`else
                    w_next = w_is_div ? ST_DIV : ST_MUL;
`endif
                end
            end
            ST_MUL, ST_DIV: begin
                if (r_cnt == CW'(1)) begin
                    w_next = ST_FIX;
                end
            end
            ST_FIX:  w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (i_flush) begin
            w_next = ST_IDLE;
        end
    end

    // State register, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opd      <= '0;
            r_rem      <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_dbz_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dbz      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= CW'(WIDTH);
                        r_is_div   <= w_is_div;
                        r_neg_lo   <= w_a_neg ^ w_b_neg;
                        r_neg_hi   <= w_a_neg && w_is_div;
                        r_dbz_pend <= w_is_div && (i_b == '0);
                        r_rem      <= '0;
                        if (w_is_div) begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_a};
                            r_opd <= w_abs_b;
                        end else begin
                            r_acc <= {{WIDTH{1'b0}}, w_abs_b};
                            r_opd <= w_abs_a;
                        end
`ifdef MDU_FAST_MUL_EN
                        if (!w_is_div) begin
                            r_cnt <= '0;
                            r_hi  <= w_fast_prod[W2-1:WIDTH];
                            r_lo  <= w_fast_prod[WIDTH-1:0];
                            r_dbz <= 1'b0;
                        end
`endif
                    end
                end
                ST_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_DIV: begin
                    r_rem            <= w_rem_next;
                    r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], w_qbit};
                    r_cnt            <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    if (!i_flush) begin
                        r_hi  <= w_fix_hi;
                        r_lo  <= w_fix_lo;
                        r_dbz <= r_dbz_pend;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_dbz  = r_dbz;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: directed vectors push expected HI/LO/dbz and
// latency; a done-driven monitor pops and compares.
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int unsigned W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_start;
    logic [1:0]   i_op;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_flush;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_hi;
    logic [W-1:0] o_lo;
    logic         o_dbz;

    mdu_iter #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_flush (i_flush),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_hi    (o_hi),
        .o_lo    (o_lo),
        .o_dbz   (o_dbz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           lat;
        int           start_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   chks = 0;
    int   errs = 0;

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
        chks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (sb.size() == 0) begin
                chks++;
                errs++;
                $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_hi"}, o_hi, mon_e.hi);
                chk({mon_e.name, "_lo"}, o_lo, mon_e.lo);
                chk({mon_e.name, "_dbz"}, W'(o_dbz), W'(mon_e.dbz));
                chk({mon_e.name, "_latency"}, W'(cyc - mon_e.start_cyc), W'(mon_e.lat));
            end
        end
    end

    // Issue one request, check busy each cycle until the cycle after done.
    // With poke set, a competing start is driven mid-operation and must be ignored.
    task automatic issue(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo, input logic exp_dbz, input bit poke);
        exp_t e;
        int   lat;
        lat         = op[1] ? DIV_LAT : MUL_LAT;
        e.name      = nm;
        e.hi        = exp_hi;
        e.lo        = exp_lo;
        e.dbz       = exp_dbz;
        e.lat       = lat;
        e.start_cyc = cyc;
        sb.push_back(e);
        i_op    = op;
        i_a     = a;
        i_b     = b;
        i_flush = 1'b0;
        i_start = 1'b1;
        for (int k = 1; k <= lat + 1; k++) begin
            tick();
            i_start = 1'b0;
            if (poke && k == 5) begin
                i_start = 1'b1;
                i_op    = MDU_MULTU;
                i_a     = 32'd1;
                i_b     = 32'd1;
            end
            chk({nm, "_busy"}, W'(o_busy), W'(k <= lat));
        end
        chk({nm, "_result_seen"}, W'(sb.size()), W'(0));
        if (sb.size() != 0) sb.delete();
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_op    = 2'd0;
        i_a     = '0;
        i_b     = '0;
        i_flush = 1'b0;
        repeat (3) tick();
        chk("rst_busy", W'(o_busy), W'(0));
        chk("rst_done", W'(o_done), W'(0));
        chk("rst_hi", o_hi, 32'h0);
        chk("rst_lo", o_lo, 32'h0);
        chk("rst_dbz", W'(o_dbz), W'(0));
        rst = 1'b0;
        tick();

        issue("mult_m1_2",   MDU_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue("multu_ff_2",  MDU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        issue("mult_m3_m5",  MDU_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0, 1'b0);
        issue("mult_min2",   MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        issue("multu_max",   MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        issue("div_m7_2",    MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue("div_7_m2",    MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
        issue("div_ovf",     MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        issue("divu_7_0",    MDU_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue("mult_after0", MDU_MULT,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0, 1'b0);
        issue("div_m8_0",    MDU_DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 1'b0);
        issue("divu_poke",   MDU_DIVU,  32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999, 1'b0, 1'b1);

        // Flush: prior result 5/9, then a DIV cancelled at cycle 10 with start also high.
        issue("divu_68_7",   MDU_DIVU,  32'd68, 32'd7, 32'd5, 32'd9, 1'b0, 1'b0);
        i_op    = MDU_DIV;
        i_a     = 32'd100;
        i_b     = 32'd3;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        chk("flush_busy_c10", W'(o_busy), W'(1));
        i_start = 1'b1;
        i_flush = 1'b1;
        i_op    = MDU_DIVU;
        tick();
        i_start = 1'b0;
        i_flush = 1'b0;
        chk("flush_busy_c11", W'(o_busy), W'(0));
        chk("flush_hold_hi", o_hi, 32'd5);
        chk("flush_hold_lo", o_lo, 32'd9);
        chk("flush_hold_dbz", W'(o_dbz), W'(0));
        issue("divu_after_flush", MDU_DIVU, 32'd100, 32'd3, 32'd1, 32'd33, 1'b0, 1'b0);

        repeat (40) tick();
        chk("sb_empty", W'(sb.size()), W'(0));
        chk("idle_at_end", W'(o_busy), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", chks, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
